// File: rtl/ser_word_rx.sv
// ser_word_rx: assembles LSB-first serial frames into WIDTH-bit words behind a valid/ready output register.
// Latency: word_valid rises 1 clk after the last frame bit. frame_err/overrun are registered.
// Backpressure: a word that completes while the output register is still full is dropped and overrun is set.
// Optional: define SER_WORD_RX_PARITY_CHECK_EN to add a trailing even-parity bit per frame and a parity_err port.
module ser_word_rx #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ser_valid,
  input  logic             ser_sof,
  input  logic             ser_data,
  output logic [WIDTH-1:0] word_data,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             frame_err,
  output logic             overrun,
  input  logic             clr_overrun
`ifdef SER_WORD_RX_PARITY_CHECK_EN
  ,
  output logic             parity_err
`endif
);

  localparam int             CW     = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST   = CW'(WIDTH - 1);
  localparam int             TW     = $clog2(TIMEOUT + 2);
  localparam int             TO_LIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

`ifdef SER_WORD_RX_PARITY_CHECK_EN
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PAR} state_t;
`else
  typedef enum logic [0:0] {S_IDLE, S_SHIFT} state_t;
`endif

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] shift_q;
  logic [TW-1:0]    to_q;
  logic [WIDTH-1:0] word_data_q;
  logic             word_valid_q;
  logic             frame_err_q;
  logic             overrun_q;

  // Per-cycle events derived from the current state and the serial input.
  logic [WIDTH-1:0] first_bit;   // new frame image: bit 0 = ser_data, rest cleared
  logic [WIDTH-1:0] word_full;   // shift register with the current bit written at cnt_q
  logic [WIDTH-1:0] cmp_word;    // word offered to the output register this cycle
  logic             cmp_vld;     // a frame completes this cycle
  logic             abort;       // the frame in progress is abandoned this cycle
  logic             to_hit;      // this quiet cycle reaches the stall limit
  logic             drop;        // a completed word finds the output register occupied

`ifdef SER_WORD_RX_PARITY_CHECK_EN
  logic             par_ok;
  logic             par_bad;
  logic             parity_err_q;
`endif

  assign first_bit = {{(WIDTH-1){1'b0}}, ser_data};
  assign to_hit    = (TIMEOUT != 0) && (to_q == TW'(TO_LIM));
  assign drop      = cmp_vld && word_valid_q && !word_ready;
`ifdef SER_WORD_RX_PARITY_CHECK_EN
  // Even parity: data bits plus the parity bit must hold an even number of ones.
  assign par_ok    = ~(^shift_q ^ ser_data);
`endif

  // Decode completion and abort events for the current cycle.
  always_comb begin
    word_full          = shift_q;
    word_full[cnt_q]   = ser_data;
    cmp_vld            = 1'b0;
    cmp_word           = shift_q;
    abort              = 1'b0;
`ifdef SER_WORD_RX_PARITY_CHECK_EN
    par_bad            = 1'b0;
`endif
    case (state_q)
      S_SHIFT: begin
        if (ser_valid) begin
          if (ser_sof) begin
            abort = 1'b1;
          end else if (cnt_q == LAST) begin
`ifndef SER_WORD_RX_PARITY_CHECK_EN
            cmp_vld  = 1'b1;
            cmp_word = word_full;
`endif
          end
        end else if (to_hit) begin
          abort = 1'b1;
        end
      end
`ifdef SER_WORD_RX_PARITY_CHECK_EN
      S_PAR: begin
        if (ser_valid) begin
          if (ser_sof) begin
            abort = 1'b1;
          end else if (par_ok) begin
            cmp_vld  = 1'b1;
            cmp_word = shift_q;
          end else begin
            abort   = 1'b1;
            par_bad = 1'b1;
          end
        end else if (to_hit) begin
          abort = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  // Frame FSM, stall timer and registered word/status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      to_q         <= '0;
      word_data_q  <= '0;
      word_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef SER_WORD_RX_PARITY_CHECK_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      frame_err_q <= abort;
`ifdef SER_WORD_RX_PARITY_CHECK_EN
      parity_err_q <= par_bad;
`endif
      case (state_q)
        S_IDLE: begin
          to_q <= '0;
          if (ser_valid && ser_sof) begin
            shift_q <= first_bit;
            cnt_q   <= CW'(1);
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (ser_valid) begin
            to_q <= '0;
            if (ser_sof) begin
              // Restart: the sof bit becomes bit 0 of a fresh frame.
              shift_q <= first_bit;
              cnt_q   <= CW'(1);
            end else begin
              shift_q <= word_full;
              if (cnt_q == LAST) begin
                cnt_q <= '0;
`ifdef SER_WORD_RX_PARITY_CHECK_EN
                state_q <= S_PAR;
`else
                state_q <= S_IDLE;
`endif
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
          end else if (to_hit) begin
            to_q    <= '0;
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else if (TIMEOUT != 0) begin
            to_q <= to_q + 1'b1;
          end
        end
`ifdef SER_WORD_RX_PARITY_CHECK_EN
        S_PAR: begin
          if (ser_valid) begin
            to_q <= '0;
            if (ser_sof) begin
              shift_q <= first_bit;
              cnt_q   <= CW'(1);
              state_q <= S_SHIFT;
            end else begin
              state_q <= S_IDLE;
            end
          end else if (to_hit) begin
            to_q    <= '0;
            state_q <= S_IDLE;
          end else if (TIMEOUT != 0) begin
            to_q <= to_q + 1'b1;
          end
        end
`endif
        default: state_q <= S_IDLE;
      endcase

      // Output register: load on completion unless still occupied, clear on accept.
      if (cmp_vld) begin
        if (!drop) begin
          word_data_q  <= cmp_word;
          word_valid_q <= 1'b1;
        end
      end else if (word_ready) begin
        word_valid_q <= 1'b0;
      end

      // A drop in the same cycle as a clear request wins.
      if (drop) begin
        overrun_q <= 1'b1;
      end else if (clr_overrun) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign word_data  = word_data_q;
  assign word_valid = word_valid_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
`ifdef SER_WORD_RX_PARITY_CHECK_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: doc/ser_word_rx.md
Name: ser_word_rx

Overview:
- Serial-to-parallel receiver. It assembles LSB-first bit frames from an upstream serial word transmitter into WIDTH-bit words.
- Completed words are presented on a valid/ready output register.
- It is the receive end of the team's serial word link and sits between the pad/serial domain logic and the word-level datapath.
- Frame errors (restart, stall timeout) and overruns are flagged.

Parameters:
- WIDTH, 8: data bits per frame; legal range 2..64.
- TIMEOUT, 16: maximum consecutive cycles without ser_valid inside a frame before the frame is aborted; 0 disables the timeout.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- ser_valid  input  1  ser_data/ser_sof qualify this cycle.
- ser_sof  input  1  start of frame; meaningful only with ser_valid.
- ser_data  input  1  serial data bit.
- word_data  output  WIDTH  assembled word, bit 0 = first received bit.
- word_valid  output  1  word_data holds an unconsumed word.
- word_ready  input  1  downstream accepts the word when word_valid && word_ready.
- frame_err  output  1  one-cycle pulse on frame abort.
- overrun  output  1  sticky: a completed word was dropped.
- clr_overrun  input  1  clears overrun.

Behaviour:
- Reset, sampled when rst_n=0 at a clk edge:
  - state=IDLE, bit counter=0, shift register=0.
  - word_data=0, word_valid=0, frame_err=0, overrun=0, timeout counter=0.
  - Reset mid-frame discards the partial frame; no frame_err is raised.
- States: IDLE, SHIFT (plus PAR when PARITY_CHECK_EN is defined).
- IDLE:
  - ser_valid && ser_sof: bit 0 = ser_data, counter=1, go to SHIFT.
  - ser_valid without sof: ignored.
- SHIFT:
  - Each ser_valid && !ser_sof shifts ser_data into bit[counter] and increments counter.
  - When the bit written is bit WIDTH-1, the frame completes that cycle: go to IDLE (or PAR).
  - ser_valid && ser_sof in SHIFT: abort the old frame, pulse frame_err next cycle, and treat this cycle as bit 0 of a new frame (counter=1, stay in SHIFT).
- Timeout:
  - The counter increments each SHIFT/PAR cycle with ser_valid=0 and resets on ser_valid.
  - Reaching TIMEOUT aborts the frame: frame_err pulse, go to IDLE.
  - TIMEOUT=0 means never.
- Word completion and the output register:
  - The completed word is loaded into word_data with word_valid=1 on the cycle after the last bit; latency is 1 clk from last bit to word_valid.
  - If word_valid=1 and not accepted on the completion cycle, the new word is dropped, word_data is unchanged, and overrun is set.
  - Accept and completion in the same cycle: the new word loads, word_valid stays 1, no overrun.
  - Accept with no completion: word_valid=0 next cycle.
  - word_data holds its value until the next load.
- overrun:
  - Set has priority over clr_overrun in the same cycle.
  - Otherwise clr_overrun clears it next cycle.
- frame_err is registered and high for exactly one cycle per abort.
- Back-to-back frames are legal: sof may arrive the cycle after the last bit; no gap is required.

Optional Feature:
- Macro: SER_WORD_RX_PARITY_CHECK_EN.
- When defined:
  - After bit WIDTH-1 the FSM enters PAR and waits for one more ser_valid bit (even parity over data+parity).
  - The timeout applies in PAR; sof in PAR aborts as in SHIFT.
  - Parity match: the word loads per the normal rules.
  - Parity mismatch: the word is dropped, frame_err pulses, and overrun is unaffected.
  - Adds output port parity_err (1 bit, one-cycle pulse coincident with frame_err on mismatch; reset 0).
- When undefined: no PAR state, no parity_err port, and the frame is WIDTH bits exactly.

Test Plan:
- WIDTH=8, word_ready=1: sof + bits 1,0,1,1,0,0,1,0 on 8 consecutive cycles -> word_valid=1 one cycle after the last bit, word_data=8'h4D, frame_err=0.
- word_ready=0: two full frames 8'hA5 then 8'h3C -> word_data stays 8'hA5, overrun=1 after the second frame. Then clr_overrun=1 and word_ready=1 for one cycle -> overrun=0, word_valid=0.
- sof, 3 bits, then sof again followed by 8'hFF frame -> one frame_err pulse on the cycle after the second sof; word_data=8'hFF.
- TIMEOUT=16: sof + 4 bits, then ser_valid=0 for 16 cycles -> frame_err pulse, FSM in IDLE. A following bit without sof is ignored; no word.
- rst_n=0 for one cycle mid-frame after 5 bits -> all outputs 0, no frame_err. The next full frame 8'h81 is received correctly.
- With SER_WORD_RX_PARITY_CHECK_EN: frame 8'h07 with parity bit 1 -> word accepted. Same frame with parity bit 0 -> parity_err and frame_err pulse, word_valid stays 0.
